pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Successor to the single-cycle RV32I control unit, for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Decodes in ID and carries control bits through internal ID/EX, EX/MEM and MEM/WB registers.
- Resolves all six branch conditions plus JAL/JALR in EX from ALU flags.
- Detects load-use hazards and inserts bubbles on stall or redirect.

Parameters:
- ALU_CTRL_W, 5, ALU control width; must be >=5 when MUL_EXT_EN is defined.
- BYTE_EN_W, 4, memory byte-enable width (data bus bytes).
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_id_i  in  32  instruction in ID; opcode, funct3, funct7 and rd/rs1/rs2 are sliced internally
- instr_valid_id_i  in  1  ID holds a real instruction
- zero_ex_i  in  1  ALU result==0 (EX)
- lt_ex_i  in  1  signed rs1<rs2 (EX)
- ltu_ex_i  in  1  unsigned rs1<rs2 (EX)
- imm_src_id_o  out  3  immediate format, combinational (0 I, 1 S, 2 B, 3 U, 4 J)
- illegal_id_o  out  1  valid instruction with unknown opcode, combinational
- stall_o  out  1  load-use hazard; hold PC and IF/ID
- flush_o  out  1  taken redirect; IF/ID must load a bubble
- alu_control_ex_o  out  ALU_CTRL_W  ALU operation
- alu_src_ex_o  out  1  0 = rs2, 1 = immediate
- pc_src_ex_o  out  1  redirect PC this cycle
- jalr_ex_o  out  1  redirect target base is rs1, not PC
- mem_wr_en_mem_o  out  1  store
- mem_rd_en_mem_o  out  1  load
- byte_en_mem_o  out  BYTE_EN_W  size mask before address shift: B 0001, H 0011, W 1111
- funct3_mem_o  out  3  load sign/size for the extender
- reg_wr_en_wb_o  out  1  register write
- result_src_wb_o  out  2  write-back source: 0 ALU, 1 mem, 2 PC+4
- rd_wb_o  out  REG_ADDR_W  destination register

Behaviour:
- Reset: all stage registers are cleared to the bubble (every enable 0, codes 0, rd 0) on the next rising edge. All EX/MEM/WB outputs are 0. flush_o=0. stall_o=0 while ID/EX is a bubble.
- Latency from ID decode: EX outputs +1 cycle, MEM +2, WB +3.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10. PASSB is used by LUI.
- SUB is selected only for R-type with funct7_5=1. I-type uses SRA when funct3=101 and funct7_5=1.
- Loads, stores, AUIPC, JAL and JALR use ADD.
- stall_o = mem_rd_en_ex & rd_ex!=0 & (rd_ex==rs1_id | rd_ex==rs2_id) & instr_valid_id_i.
- Bubble enters ID/EX when any of: stall_o, pc_src_ex_o, !instr_valid_id_i, illegal_id_o.
- The EX/MEM and MEM/WB registers always advance.
- pc_src_ex_o = jump_ex | (branch_ex & cond). cond is selected by funct3_ex: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. funct3 010 and 011 mean not taken.
- flush_o = pc_src_ex_o.
- Stall and redirect in the same cycle: redirect wins; stall_o is still reported, and the bubble is inserted once.
- A write to rd=0 gives reg_wr_en_wb_o=0.
- Stores and branches force reg_wr_en=0.
- Reset asserted mid-stream flushes all in-flight control. There is no partial commit after the reset edge.

Optional Feature:
- Macro: MUL_EXT_EN.
- Defined: R-type with funct7=0000001 decodes RV32M. Codes are 16+funct3 (MUL 16 through REMU 23).
- Undefined: funct7=0000001 asserts illegal_id_o and inserts a bubble.

Decomposition:
- Package ctrl_pkg holds: opcode constants, the ALU code enum, the result_src enum, the imm_src enum, and a stage control struct.
- The struct fields are: reg_wr_en, mem_wr_en, mem_rd_en, byte_en, result_src, alu_src, alu_control, branch, jump, jalr, funct3, rd.
- Sub-module pipe_decoder is the combinational ID decode from instruction to stage struct. The top holds the registers, hazard logic and branch resolution.

Test Plan:
- add x3,x1,x2 (0x002081B3), valid: alu_control_ex_o=0 at +1; reg_wr_en_wb_o=1, rd_wb_o=3, result_src=0 at +3.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x7: stall_o=1 for exactly one cycle; a bubble enters EX; the add reaches EX one cycle late.
- bne (funct3=001) with zero_ex_i=0: pc_src_ex_o=1 and flush_o=1. The next instruction in ID does not reach EX. With zero_ex_i=1: no redirect.
- Instruction 0x0000007F: illegal_id_o=1 and a bubble in EX. sb x2,0(x1) (0x00208023): mem_wr_en_mem_o=1, byte_en_mem_o=0001, reg_wr_en=0.
- jalr x1,0(x5) (0x000280E7): pc_src_ex_o=1 and jalr_ex_o=1; result_src_wb_o=2 and rd_wb_o=1 at +3.
- Reset mid-stream and the MUL_EXT_EN variant:
  - rst pulsed while three instructions are in flight: all EX/MEM/WB outputs are 0 the following cycle.
  - mul x3,x1,x2 (0x022081B3) with MUL_EXT_EN defined: code 16.
  - The same instruction without the macro: illegal_id_o=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined RV32I control unit: opcodes, ALU/result/immediate codes
// and the control bundle carried through the ID/EX, EX/MEM and MEM/WB registers.
package ctrl_pkg;

  localparam int unsigned AluCtrlW = 5;
  localparam int unsigned ByteEnW  = 4;
  localparam int unsigned RegAddrW = 5;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [AluCtrlW-1:0] {
    AluAdd   = 5'd0,
    AluSub   = 5'd1,
    AluAnd   = 5'd2,
    AluOr    = 5'd3,
    AluXor   = 5'd4,
    AluSll   = 5'd5,
    AluSrl   = 5'd6,
    AluSra   = 5'd7,
    AluSlt   = 5'd8,
    AluSltu  = 5'd9,
    AluPassB = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {ResAlu = 2'd0, ResMem = 2'd1, ResPc4 = 2'd2} result_src_e;

  typedef enum logic [2:0] {
    ImmI = 3'd0, ImmS = 3'd1, ImmB = 3'd2, ImmU = 3'd3, ImmJ = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic                reg_wr_en;
    logic                mem_wr_en;
    logic                mem_rd_en;
    logic [ByteEnW-1:0]  byte_en;
    result_src_e         result_src;
    logic                alu_src;
    logic [AluCtrlW-1:0] alu_control;
    logic                branch;
    logic                jump;
    logic                jalr;
    logic [2:0]          funct3;
    logic [RegAddrW-1:0] rd;
  } stage_ctrl_t;

  // Shared by R-type and OP-IMM; only R-type may select SUB.
  function automatic logic [AluCtrlW-1:0] alu_arith(input logic [2:0] f3, input logic f7_5,
                                                    input logic is_r);
    case (f3)
      3'b000:  alu_arith = (is_r && f7_5) ? AluSub : AluAdd;
      3'b001:  alu_arith = AluSll;
      3'b010:  alu_arith = AluSlt;
      3'b011:  alu_arith = AluSltu;
      3'b100:  alu_arith = AluXor;
      3'b101:  alu_arith = f7_5 ? AluSra : AluSrl;
      3'b110:  alu_arith = AluOr;
      default: alu_arith = AluAnd;
    endcase
  endfunction

  function automatic logic [ByteEnW-1:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/pipe_decoder.sv
// Combinational ID-stage decode from a 32-bit instruction to the stage control bundle.
// MUL_EXT_EN enables RV32M decode (codes 16+funct3); otherwise funct7=0000001 is illegal.
module pipe_decoder import ctrl_pkg::*; (
  input  logic [31:0]  instr_i,
  input  logic         valid_i,
  output stage_ctrl_t  ctrl_o,
  output imm_src_e     imm_src_o,
  output logic         illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       known;
  logic       writes;
  logic       unused_rs;

  assign opcode    = instr_i[6:0];
  assign rd        = instr_i[11:7];
  assign f3        = instr_i[14:12];
  assign f7        = instr_i[31:25];
  assign unused_rs = ^instr_i[24:15];

  always_comb begin
    ctrl_o    = '0;
    imm_src_o = ImmI;
    known     = 1'b1;
    writes    = 1'b0;
    case (opcode)
      OpcR: begin
        writes        = 1'b1;
        ctrl_o.funct3 = f3;
        if (f7 == 7'b0000001) begin
`ifdef MUL_EXT_EN
          ctrl_o.alu_control = {2'b10, f3};
`else
          known = 1'b0;
`endif
        end else begin
          ctrl_o.alu_control = alu_arith(f3, f7[5], 1'b1);
        end
      end
      OpcImm: begin
        writes             = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.funct3      = f3;
        ctrl_o.alu_control = alu_arith(f3, f7[5], 1'b0);
      end
      OpcLoad: begin
        writes            = 1'b1;
        ctrl_o.mem_rd_en  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = ResMem;
        ctrl_o.byte_en    = size_mask(f3);
        ctrl_o.funct3     = f3;
      end
      OpcStore: begin
        imm_src_o        = ImmS;
        ctrl_o.mem_wr_en = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.byte_en   = size_mask(f3);
        ctrl_o.funct3    = f3;
      end
      OpcBranch: begin
        imm_src_o     = ImmB;
        ctrl_o.branch = 1'b1;
        ctrl_o.funct3 = f3;
      end
      OpcJal: begin
        imm_src_o         = ImmJ;
        writes            = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = ResPc4;
      end
      OpcJalr: begin
        writes            = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.jalr       = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = ResPc4;
        ctrl_o.funct3     = f3;
      end
      OpcLui: begin
        imm_src_o          = ImmU;
        writes             = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = AluPassB;
      end
      OpcAuipc: begin
        imm_src_o      = ImmU;
        writes         = 1'b1;
        ctrl_o.alu_src = 1'b1;
      end
      default: known = 1'b0;
    endcase
    // x0 is never written, so its rd is dropped as well to keep hazard compares clean.
    ctrl_o.reg_wr_en = writes && (rd != '0);
    ctrl_o.rd        = ctrl_o.reg_wr_en ? rd : '0;
    if (!known) begin
      ctrl_o = '0;
    end
  end

  assign illegal_o = valid_i && !known;

endmodule

// File: rtl/pipelined_control_unit.sv
// 5-stage RV32I control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, load-use stall,
// EX branch resolution and redirect flush. MUL_EXT_EN enables RV32M decode in pipe_decoder.
module pipelined_control_unit import ctrl_pkg::*; #(
  parameter int unsigned ALU_CTRL_W = 5,
  parameter int unsigned BYTE_EN_W  = 4,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_id_i,
  input  logic                  instr_valid_id_i,
  input  logic                  zero_ex_i,
  input  logic                  lt_ex_i,
  input  logic                  ltu_ex_i,
  output logic [2:0]            imm_src_id_o,
  output logic                  illegal_id_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [ALU_CTRL_W-1:0] alu_control_ex_o,
  output logic                  alu_src_ex_o,
  output logic                  pc_src_ex_o,
  output logic                  jalr_ex_o,
  output logic                  mem_wr_en_mem_o,
  output logic                  mem_rd_en_mem_o,
  output logic [BYTE_EN_W-1:0]  byte_en_mem_o,
  output logic [2:0]            funct3_mem_o,
  output logic                  reg_wr_en_wb_o,
  output logic [1:0]            result_src_wb_o,
  output logic [REG_ADDR_W-1:0] rd_wb_o
);

  stage_ctrl_t dec_ctrl;
  imm_src_e    dec_imm;
  stage_ctrl_t ex_d, ex_q, mem_q, wb_q;
  logic [RegAddrW-1:0] rs1_id, rs2_id;
  logic        cond;
  logic        unused_wb;

  pipe_decoder u_dec (
    .instr_i   (instr_id_i),
    .valid_i   (instr_valid_id_i),
    .ctrl_o    (dec_ctrl),
    .imm_src_o (dec_imm),
    .illegal_o (illegal_id_o)
  );

  assign imm_src_id_o = dec_imm;
  assign rs1_id       = instr_id_i[19:15];
  assign rs2_id       = instr_id_i[24:20];

  assign stall_o = ex_q.mem_rd_en && (ex_q.rd != '0) &&
                   ((ex_q.rd == rs1_id) || (ex_q.rd == rs2_id)) && instr_valid_id_i;

  always_comb begin
    cond = 1'b0;
    case (ex_q.funct3)
      3'b000:  cond = zero_ex_i;
      3'b001:  cond = !zero_ex_i;
      3'b100:  cond = lt_ex_i;
      3'b101:  cond = !lt_ex_i;
      3'b110:  cond = ltu_ex_i;
      3'b111:  cond = !ltu_ex_i;
      default: cond = 1'b0;
    endcase
  end

  assign pc_src_ex_o = ex_q.jump || (ex_q.branch && cond);
  assign flush_o     = pc_src_ex_o;

  always_comb begin
    ex_d = dec_ctrl;
    if (stall_o || pc_src_ex_o || !instr_valid_id_i || illegal_id_o) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign alu_control_ex_o = ALU_CTRL_W'(ex_q.alu_control);
  assign alu_src_ex_o     = ex_q.alu_src;
  assign jalr_ex_o        = ex_q.jalr;
  assign mem_wr_en_mem_o  = mem_q.mem_wr_en;
  assign mem_rd_en_mem_o  = mem_q.mem_rd_en;
  assign byte_en_mem_o    = BYTE_EN_W'(mem_q.byte_en);
  assign funct3_mem_o     = mem_q.funct3;
  assign reg_wr_en_wb_o   = wb_q.reg_wr_en;
  assign result_src_wb_o  = wb_q.result_src;
  assign rd_wb_o          = REG_ADDR_W'(wb_q.rd);
  assign unused_wb        = ^wb_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Table-driven bench for pipelined_control_unit; MEM/WB expectations go through a scoreboard
// queue. Honours MUL_EXT_EN for the RV32M vector.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_id_i;
  logic        instr_valid_id_i, zero_ex_i, lt_ex_i, ltu_ex_i;
  logic [2:0]  imm_src_id_o;
  logic        illegal_id_o, stall_o, flush_o;
  logic [4:0]  alu_control_ex_o;
  logic        alu_src_ex_o, pc_src_ex_o, jalr_ex_o;
  logic        mem_wr_en_mem_o, mem_rd_en_mem_o;
  logic [3:0]  byte_en_mem_o;
  logic [2:0]  funct3_mem_o;
  logic        reg_wr_en_wb_o;
  logic [1:0]  result_src_wb_o;
  logic [4:0]  rd_wb_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_control_unit dut (
    .clk              (clk),
    .rst              (rst),
    .instr_id_i       (instr_id_i),
    .instr_valid_id_i (instr_valid_id_i),
    .zero_ex_i        (zero_ex_i),
    .lt_ex_i          (lt_ex_i),
    .ltu_ex_i         (ltu_ex_i),
    .imm_src_id_o     (imm_src_id_o),
    .illegal_id_o     (illegal_id_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .alu_control_ex_o (alu_control_ex_o),
    .alu_src_ex_o     (alu_src_ex_o),
    .pc_src_ex_o      (pc_src_ex_o),
    .jalr_ex_o        (jalr_ex_o),
    .mem_wr_en_mem_o  (mem_wr_en_mem_o),
    .mem_rd_en_mem_o  (mem_rd_en_mem_o),
    .byte_en_mem_o    (byte_en_mem_o),
    .funct3_mem_o     (funct3_mem_o),
    .reg_wr_en_wb_o   (reg_wr_en_wb_o),
    .result_src_wb_o  (result_src_wb_o),
    .rd_wb_o          (rd_wb_o)
  );

  typedef struct packed {
    logic       mw;
    logic       mr;
    logic [3:0] be;
    logic [2:0] f3;
    logic       wr;
    logic [1:0] rs;
    logic [4:0] rd;
  } down_t;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [2:0]  flags;   // {zero, lt, ltu} for the instruction currently in EX
    logic        ill;
    logic [2:0]  imm;
    logic        stall;
    logic        pc;
    logic        jalr;
    logic        bub;
    logic [4:0]  alu;
    logic        src;
    down_t       d;
  } vec_t;

  vec_t  vecs[$];
  down_t sb[$];

  function automatic down_t dn(logic mw, logic mr, logic [3:0] be, logic [2:0] f3, logic wr,
                               logic [1:0] rs, logic [4:0] rd);
    dn = '{mw: mw, mr: mr, be: be, f3: f3, wr: wr, rs: rs, rd: rd};
  endfunction

  function automatic vec_t mk(logic [31:0] instr, logic valid, logic [2:0] flags, logic ill,
                              logic [2:0] imm, logic stall, logic pc, logic jalr, logic bub,
                              logic [4:0] alu, logic src, down_t d);
    mk = '{instr: instr, valid: valid, flags: flags, ill: ill, imm: imm, stall: stall, pc: pc,
           jalr: jalr, bub: bub, alu: alu, src: src, d: d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " alu_ex"}, alu_control_ex_o, 0);
    chk({tag, " alu_src_ex"}, alu_src_ex_o, 0);
    chk({tag, " pc_src"}, pc_src_ex_o, 0);
    chk({tag, " flush"}, flush_o, 0);
    chk({tag, " jalr"}, jalr_ex_o, 0);
    chk({tag, " stall"}, stall_o, 0);
    chk({tag, " mem_wr"}, mem_wr_en_mem_o, 0);
    chk({tag, " mem_rd"}, mem_rd_en_mem_o, 0);
    chk({tag, " byte_en"}, byte_en_mem_o, 0);
    chk({tag, " funct3_mem"}, funct3_mem_o, 0);
    chk({tag, " reg_wr"}, reg_wr_en_wb_o, 0);
    chk({tag, " result_src"}, result_src_wb_o, 0);
    chk({tag, " rd_wb"}, rd_wb_o, 0);
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid);
    instr_id_i       = instr;
    instr_valid_id_i = valid;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] IAdd  = 32'h002081B3;
  localparam logic [31:0] ILw   = 32'h0000A283;
  localparam logic [31:0] ISb   = 32'h00208023;
  localparam logic [31:0] ILui  = 32'h12345437;

  initial begin
    down_t z;
    z = '0;

    // {instr, valid, {zero,lt,ltu}, ill, imm, stall, pc, jalr, bubble, alu, src, downstream}
    vecs.push_back(mk(IAdd, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 0, 1, 0, 3)));
    vecs.push_back(mk(32'h40208233, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, dn(0, 0, 0, 0, 1, 0, 4)));
    vecs.push_back(mk(ILw, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, dn(0, 1, 4'hF, 2, 1, 1, 5)));
    vecs.push_back(mk(32'h00728333, 1, 3'b000, 0, 0, 1, 0, 0, 1, 0, 0, z));
    vecs.push_back(mk(32'h00728333, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 0, 1, 0, 6)));
    vecs.push_back(mk(ISb, 1, 3'b000, 0, 1, 0, 0, 0, 0, 0, 1, dn(1, 0, 4'h1, 0, 0, 0, 0)));
    vecs.push_back(mk(32'h00209463, 1, 3'b000, 0, 2, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(IAdd, 1, 3'b000, 0, 0, 0, 1, 0, 1, 0, 0, z));
    vecs.push_back(mk(32'h00209463, 1, 3'b000, 0, 2, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(IAdd, 1, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 0, 1, 0, 3)));
    vecs.push_back(mk(32'h0000007F, 1, 3'b000, 1, 0, 0, 0, 0, 1, 0, 0, z));
    vecs.push_back(mk(32'h000280E7, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, dn(0, 0, 0, 0, 1, 2, 1)));
    vecs.push_back(mk(IAdd, 1, 3'b000, 0, 0, 0, 1, 1, 1, 0, 0, z));
    vecs.push_back(mk(32'h000000EF, 1, 3'b000, 0, 4, 0, 0, 0, 0, 0, 1, dn(0, 0, 0, 0, 1, 2, 1)));
    vecs.push_back(mk(ILui, 1, 3'b000, 0, 3, 0, 1, 0, 1, 0, 0, z));
    vecs.push_back(mk(ILui, 1, 3'b000, 0, 3, 0, 0, 0, 0, 10, 1, dn(0, 0, 0, 0, 1, 0, 8)));
    vecs.push_back(mk(32'h4030D513, 1, 3'b000, 0, 0, 0, 0, 0, 0, 7, 1, dn(0, 0, 0, 5, 1, 0, 10)));
    vecs.push_back(mk(32'h00108013, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, z));
    vecs.push_back(mk(32'h0020C463, 1, 3'b000, 0, 2, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 4, 0, 0, 0)));
    vecs.push_back(mk(32'h00000000, 0, 3'b010, 0, 0, 0, 1, 0, 1, 0, 0, z));
    vecs.push_back(mk(32'h0020F463, 1, 3'b000, 0, 2, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 7, 0, 0, 0)));
    vecs.push_back(mk(IAdd, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 0, 1, 0, 3)));
    vecs.push_back(mk(32'h0000A003, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, dn(0, 1, 4'hF, 2, 0, 1, 0)));
    vecs.push_back(mk(32'h000001B3, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, dn(0, 0, 0, 0, 1, 0, 3)));
`ifdef MUL_EXT_EN
    vecs.push_back(mk(32'h022081B3, 1, 3'b000, 0, 0, 0, 0, 0, 0, 16, 0, dn(0, 0, 0, 0, 1, 0, 3)));
`else
    vecs.push_back(mk(32'h022081B3, 1, 3'b000, 1, 0, 0, 0, 0, 1, 0, 0, z));
`endif
    vecs.push_back(mk(32'h00000000, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, z));
    vecs.push_back(mk(32'h00009283, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, dn(0, 1, 4'h3, 1, 1, 1, 5)));
    vecs.push_back(mk(32'h00000000, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, z));
    vecs.push_back(mk(32'h00000000, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, z));

    rst              = 1'b1;
    instr_id_i       = '0;
    instr_valid_id_i = 1'b0;
    {zero_ex_i, lt_ex_i, ltu_ex_i} = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    sb.push_back(z);
    sb.push_back(z);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t  t;
      down_t e;
      down_t em;
      down_t ew;
      t = vecs[i];
      instr_id_i       = t.instr;
      instr_valid_id_i = t.valid;
      {zero_ex_i, lt_ex_i, ltu_ex_i} = t.flags;
      #1;
      chk($sformatf("v%0d illegal", i), illegal_id_o, t.ill);
      chk($sformatf("v%0d imm_src", i), imm_src_id_o, t.imm);
      chk($sformatf("v%0d stall", i), stall_o, t.stall);
      chk($sformatf("v%0d pc_src", i), pc_src_ex_o, t.pc);
      chk($sformatf("v%0d flush", i), flush_o, t.pc);
      chk($sformatf("v%0d jalr", i), jalr_ex_o, t.jalr);
      e = t.bub ? '0 : t.d;
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d alu_ex", i), alu_control_ex_o, t.bub ? 5'd0 : t.alu);
      chk($sformatf("v%0d alu_src_ex", i), alu_src_ex_o, t.bub ? 1'b0 : t.src);
      em = sb[1];
      ew = sb.pop_front();
      chk($sformatf("v%0d mem_wr", i), mem_wr_en_mem_o, em.mw);
      chk($sformatf("v%0d mem_rd", i), mem_rd_en_mem_o, em.mr);
      chk($sformatf("v%0d byte_en", i), byte_en_mem_o, em.be);
      chk($sformatf("v%0d funct3_mem", i), funct3_mem_o, em.f3);
      chk($sformatf("v%0d reg_wr", i), reg_wr_en_wb_o, ew.wr);
      chk($sformatf("v%0d result_src", i), result_src_wb_o, ew.rs);
      chk($sformatf("v%0d rd_wb", i), rd_wb_o, ew.rd);
    end

    // Reset with lw in WB, sb in MEM and lui in EX: nothing may survive the edge.
    {zero_ex_i, lt_ex_i, ltu_ex_i} = 3'b000;
    drive(ILw, 1'b1);
    drive(ISb, 1'b1);
    drive(ILui, 1'b1);
    chk("pre-reset rd_wb", rd_wb_o, 5);
    chk("pre-reset mem_wr", mem_wr_en_mem_o, 1);
    chk("pre-reset alu_ex", alu_control_ex_o, 10);
    rst = 1'b1;
    drive(IAdd, 1'b1);
    chk_zero_outputs("midrst");
    rst = 1'b0;
    drive(32'h0, 1'b0);
    chk_zero_outputs("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
